// File: rtl/matrix_generate_kxk.sv
// KxK sliding-window generator for a raster pixel stream: KSIZE-1 line buffers
// feed a KxK tap register array that trails the accepted pixel by two cycles.
module matrix_generate_kxk #(
    parameter int DATA_WIDTH  = 8,
    parameter int IMG_WIDTH   = 640,
    parameter int KSIZE       = 3,
    parameter int BORDER_MODE = 0
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              in_vsync,
    input  logic                              in_href,
    input  logic                              in_valid,
    input  logic [DATA_WIDTH-1:0]             in_data,
    output logic                              win_vsync,
    output logic                              win_href,
    output logic                              win_valid,
    output logic [KSIZE*KSIZE*DATA_WIDTH-1:0] win_data,
    output logic                              win_full,
    output logic                              err_overflow
);
    localparam int CW  = $clog2(IMG_WIDTH + 1);
    localparam int AW  = $clog2(IMG_WIDTH);
    localparam int RW  = 16;
    localparam int LBW = (KSIZE - 1) * DATA_WIDTH;
    localparam int WW  = KSIZE * KSIZE * DATA_WIDTH;

    if (KSIZE != 3 && KSIZE != 5) begin : g_bad_ksize
        $error("matrix_generate_kxk: KSIZE must be 3 or 5");
    end

    logic                  vsync_q, vsync_d, href_q, href_d;
    logic                  win_vsync_q, win_vsync_d, win_href_q, win_href_d;
    logic [CW-1:0]         col_q, col_d;
    logic [RW-1:0]         row_q, row_d;
    logic                  line_px_q, line_px_d;
    logic                  err_q, err_d;
    logic                  acc1_q, acc1_d;
    logic [DATA_WIDTH-1:0] data1_q, data1_d;
    logic [CW-1:0]         col1_q, col1_d;
    logic [RW-1:0]         row1_q, row1_d;
    logic                  clr1_q, clr1_d;
    logic                  win_valid_q, win_valid_d;
    logic [WW-1:0]         win_q, win_d, win_base;
    logic [CW-1:0]         win_col_q, win_col_d;
    logic [RW-1:0]         win_row_q, win_row_d;
    logic [LBW-1:0]        rd_q;
    logic [LBW-1:0]        lb_mem [IMG_WIDTH];

    logic          vsync_rise, href_rise, href_fall, accept, overflow, accept_ok;
    logic [CW-1:0] cur_col;
    logic [RW-1:0] cur_row;

    // A pixel is taken on every cycle with in_href && in_valid; there is no back-pressure.
    always_comb begin
        vsync_rise  = in_vsync & ~vsync_q;
        href_rise   = in_href & ~href_q;
        href_fall   = ~in_href & href_q;
        accept      = in_href & in_valid;
        cur_col     = href_rise ? '0 : col_q;
        cur_row     = vsync_rise ? '0 : row_q;
        overflow    = accept && (cur_col == CW'(IMG_WIDTH));
        accept_ok   = accept && !overflow;

        vsync_d     = in_vsync;
        href_d      = in_href;
        win_vsync_d = vsync_q;
        win_href_d  = href_q;
        col_d       = accept_ok ? cur_col + CW'(1) : cur_col;
        line_px_d   = href_rise ? accept : (line_px_q | accept);
        err_d       = err_q | overflow;

        row_d = row_q;
        if (vsync_rise) begin
            row_d = '0;
        end else if (href_fall && line_px_q && row_q != '1) begin
            row_d = row_q + RW'(1);
        end

        acc1_d      = accept_ok;
        data1_d     = in_data;
        col1_d      = cur_col;
        row1_d      = cur_row;
        clr1_d      = href_rise;
        win_valid_d = acc1_q;
    end

    // New column enters on the right: oldest buffered line on top, live pixel at the bottom.
    always_comb begin
        win_base  = clr1_q ? '0 : win_q;
        win_d     = win_base;
        win_row_d = win_row_q;
        win_col_d = win_col_q;
        if (acc1_q) begin
            for (int i = 0; i < KSIZE; i++) begin
                for (int j = 0; j < KSIZE - 1; j++) begin
                    win_d[(i*KSIZE+j)*DATA_WIDTH +: DATA_WIDTH] =
                        win_base[(i*KSIZE+j+1)*DATA_WIDTH +: DATA_WIDTH];
                end
            end
            for (int i = 0; i < KSIZE - 1; i++) begin
                win_d[(i*KSIZE+KSIZE-1)*DATA_WIDTH +: DATA_WIDTH] =
                    rd_q[(KSIZE-2-i)*DATA_WIDTH +: DATA_WIDTH];
            end
            win_d[(KSIZE*KSIZE-1)*DATA_WIDTH +: DATA_WIDTH] = data1_q;
            win_row_d = row1_q;
            win_col_d = col1_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q     <= 1'b0;
            href_q      <= 1'b0;
            win_vsync_q <= 1'b0;
            win_href_q  <= 1'b0;
            col_q       <= '0;
            row_q       <= '0;
            line_px_q   <= 1'b0;
            err_q       <= 1'b0;
            acc1_q      <= 1'b0;
            data1_q     <= '0;
            col1_q      <= '0;
            row1_q      <= '0;
            clr1_q      <= 1'b0;
            win_valid_q <= 1'b0;
            win_q       <= '0;
            win_col_q   <= '0;
            win_row_q   <= '0;
        end else begin
            vsync_q     <= vsync_d;
            href_q      <= href_d;
            win_vsync_q <= win_vsync_d;
            win_href_q  <= win_href_d;
            col_q       <= col_d;
            row_q       <= row_d;
            line_px_q   <= line_px_d;
            err_q       <= err_d;
            acc1_q      <= acc1_d;
            data1_q     <= data1_d;
            col1_q      <= col1_d;
            row1_q      <= row1_d;
            clr1_q      <= clr1_d;
            win_valid_q <= win_valid_d;
            win_q       <= win_d;
            win_col_q   <= win_col_d;
            win_row_q   <= win_row_d;
        end
    end

    // Read in the accept cycle, write the shifted word back one cycle later;
    // consecutive accepts always use different columns, so no bypass is needed.
    always_ff @(posedge clk) begin
        if (accept_ok) begin
            rd_q <= lb_mem[cur_col[AW-1:0]];
        end
        if (acc1_q) begin
            lb_mem[col1_q[AW-1:0]] <= {rd_q[LBW-DATA_WIDTH-1:0], data1_q};
        end
    end

    always_comb begin
        win_data = win_q;
        if (BORDER_MODE == 1) begin
            for (int i = 0; i < KSIZE; i++) begin
                for (int j = 0; j < KSIZE; j++) begin
                    if ((32'(win_row_q) < 32'(KSIZE - 1 - i)) ||
                        (32'(win_col_q) < 32'(KSIZE - 1 - j))) begin
                        win_data[(i*KSIZE+j)*DATA_WIDTH +: DATA_WIDTH] = '0;
                    end
                end
            end
        end
    end

    assign win_vsync    = win_vsync_q;
    assign win_href     = win_href_q;
    assign win_valid    = win_valid_q;
    assign win_full     = win_valid_q && (32'(win_row_q) >= 32'(KSIZE - 1)) &&
                          (32'(win_col_q) >= 32'(KSIZE - 1));
    assign err_overflow = err_q;

endmodule

// File: tb/tb_matrix_generate_kxk.sv
// Bench for matrix_generate_kxk: three instances (K3 raw, K3 zero-border, K5 raw)
// share one stimulus stream and are scored against a per-column pixel history model.
module tb_matrix_generate_kxk;
  localparam int IW = 8;

  typedef struct packed {
    logic [31:0]  cyc;
    logic [199:0] data;
    logic [199:0] mask;
    logic         full;
  } win_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_vsync = 1'b0;
  logic         in_href = 1'b0;
  logic         in_valid = 1'b0;
  logic [7:0]   in_data = 8'h00;
  logic [2:0]   wv, whr, wvl, wfl, wer;
  logic [71:0]  wd0, wd1;
  logic [199:0] wd2;

  matrix_generate_kxk #(.DATA_WIDTH(8), .IMG_WIDTH(IW), .KSIZE(3), .BORDER_MODE(0)) u_k3 (
    .clk(clk), .rst_n(rst_n), .in_vsync(in_vsync), .in_href(in_href), .in_valid(in_valid),
    .in_data(in_data), .win_vsync(wv[0]), .win_href(whr[0]), .win_valid(wvl[0]),
    .win_data(wd0), .win_full(wfl[0]), .err_overflow(wer[0]));

  matrix_generate_kxk #(.DATA_WIDTH(8), .IMG_WIDTH(IW), .KSIZE(3), .BORDER_MODE(1)) u_k3b (
    .clk(clk), .rst_n(rst_n), .in_vsync(in_vsync), .in_href(in_href), .in_valid(in_valid),
    .in_data(in_data), .win_vsync(wv[1]), .win_href(whr[1]), .win_valid(wvl[1]),
    .win_data(wd1), .win_full(wfl[1]), .err_overflow(wer[1]));

  matrix_generate_kxk #(.DATA_WIDTH(8), .IMG_WIDTH(IW), .KSIZE(5), .BORDER_MODE(0)) u_k5 (
    .clk(clk), .rst_n(rst_n), .in_vsync(in_vsync), .in_href(in_href), .in_valid(in_valid),
    .in_data(in_data), .win_vsync(wv[2]), .win_href(whr[2]), .win_valid(wvl[2]),
    .win_data(wd2), .win_full(wfl[2]), .err_overflow(wer[2]));

  // ---------------- clock / reset / cycle count ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  int checks = 0;
  int errors = 0;

  // ---------------- scoreboard storage ----------------
  win_t       exp_q [3][$];
  win_t       obs_q [3][$];
  logic [1:0] in_hist [2048];
  logic [1:0] out_hist [3][2048];

  function automatic logic [199:0] get_wd(input int d);
    if (d == 0) return 200'(wd0);
    if (d == 1) return 200'(wd1);
    return wd2;
  endfunction

  always @(negedge clk) begin
    win_t w;
    if (cyc < 2048) in_hist[cyc] = {in_vsync, in_href};
    for (int d = 0; d < 3; d++) begin
      if (cyc < 2048) out_hist[d][cyc] = {wv[d], whr[d]};
      if (wvl[d] === 1'b1) begin
        w      = '0;
        w.cyc  = cyc;
        w.data = get_wd(d);
        w.full = wfl[d];
        obs_q[d].push_back(w);
      end
    end
  end

  // ---------------- reference model ----------------
  logic [7:0] colhist [IW][$];
  int m_row = 0;
  int m_col = 0;
  bit m_line_px = 0;
  bit m_err = 0;
  bit m_href_p = 0;
  bit m_vs_p = 0;

  function automatic int ks(input int d);
    return (d == 2) ? 5 : 3;
  endfunction

  // Tap (i,j) is the pixel K-1-j columns left of the newest one, taken K-1-i
  // lines back in that column's write history; columns left of the line start are 0.
  function automatic win_t model_window(input int k, input bit bm, input int due);
    win_t w;
    int   cc, dep, base, sz;
    w = '0;
    w.cyc = due;
    for (int i = 0; i < k; i++) begin
      for (int j = 0; j < k; j++) begin
        cc   = m_col - (k - 1 - j);
        dep  = k - 1 - i;
        base = (i * k + j) * 8;
        sz   = (cc >= 0) ? colhist[cc].size() : 0;
        if (bm && (m_row < k - 1 - i || m_col < k - 1 - j)) begin
          w.mask[base +: 8] = 8'hFF;
        end else if (cc < 0) begin
          w.mask[base +: 8] = 8'hFF;
        end else if (sz > dep) begin
          w.data[base +: 8] = colhist[cc][sz - 1 - dep];
          w.mask[base +: 8] = 8'hFF;
        end
      end
    end
    w.full = (m_row >= k - 1) && (m_col >= k - 1);
    return w;
  endfunction

  function automatic void model_step(input bit vs, input bit hr, input bit vl, input logic [7:0] dat);
    if (vs && !m_vs_p) m_row = 0;
    else if (!hr && m_href_p && m_line_px && m_row < 65535) m_row = m_row + 1;
    if (hr && !m_href_p) begin
      m_col = 0;
      m_line_px = 0;
    end
    if (hr && vl) begin
      m_line_px = 1;
      if (m_col == IW) begin
        m_err = 1;
      end else begin
        colhist[m_col].push_back(dat);
        if (colhist[m_col].size() > 8) void'(colhist[m_col].pop_front());
        for (int d = 0; d < 3; d++) exp_q[d].push_back(model_window(ks(d), d == 1, cyc + 2));
        m_col = m_col + 1;
      end
    end
    m_vs_p = vs;
    m_href_p = hr;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input bit vs, input bit hr, input bit vl, input logic [7:0] dat);
    @(posedge clk);
    #1;
    in_vsync = vs;
    in_href  = hr;
    in_valid = vl;
    in_data  = dat;
    model_step(vs, hr, vl, dat);
  endtask

  task automatic start_frame();
    drive(1, 0, 0, 8'h00);
    drive(1, 0, 0, 8'h00);
    drive(0, 0, 0, 8'h00);
    drive(0, 0, 0, 8'h00);
  endtask

  // mode 0: continuous valid, 1: valid toggling 1/0, 2: random valid
  task automatic send_line(input int row, input int npx, input int mode, input bit rnd);
    int c = 0;
    int k = 0;
    bit v;
    logic [7:0] px;
    while (c < npx) begin
      v  = (mode == 0) ? 1'b1 : (mode == 1) ? ((k % 2) == 0) : 1'($urandom_range(0, 1));
      px = rnd ? 8'($urandom_range(0, 255)) : 8'(row * 16 + c);
      drive(0, 1, v, px);
      if (v) c++;
      k++;
    end
    drive(0, 0, 0, 8'h00);
    drive(0, 0, 1, 8'hAA);
    drive(0, 0, 0, 8'h00);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if ({wv[d], whr[d], wvl[d], wfl[d], wer[d]} !== 5'b0) begin
        errors++;
        $display("FAIL reset_ctl dut%0d: got %b, expected 00000", d, {wv[d], whr[d], wvl[d], wfl[d], wer[d]});
      end
      checks++;
      if (get_wd(d) !== 200'h0) begin
        errors++;
        $display("FAIL reset_data dut%0d: got %h, expected 0", d, get_wd(d));
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if ({wvl[d], wer[d]} !== 2'b00) begin
        errors++;
        $display("FAIL idle_after_reset dut%0d: got valid/err %b, expected 00", d, {wvl[d], wer[d]});
      end
    end
  endtask

  task automatic test_basic();
    int   start_c, end_c, bad;
    win_t e, o;
    start_c = cyc;
    start_frame();
    for (int r = 0; r < 4; r++) send_line(r, 8, 0, 0);
    repeat (6) drive(0, 0, 0, 8'h00);
    end_c = cyc;
    for (int d = 0; d < 3; d++) begin
      bad = 0;
      for (int c = start_c + 2; c < end_c && c < 2048; c++) if (out_hist[d][c] !== in_hist[c - 2]) bad++;
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL sync_delay dut%0d: got %0d cycles where vsync/href differ from input 2 cycles earlier, expected 0", d, bad);
      end
    end
    checks++;
    if (obs_q[0].size() <= 18) begin
      errors++;
      $display("FAIL k3_r2c2 present: got %0d windows, expected more than 18", obs_q[0].size());
    end else begin
      o = obs_q[0][18];
      if (o.data[71:0] !== 72'h22_21_20_12_11_10_02_01_00 || o.full !== 1'b1) begin
        errors++;
        $display("FAIL k3_r2c2: got data=%h full=%b, expected data=222120121110020100 full=1", o.data[71:0], o.full);
      end
    end
    checks++;
    if (obs_q[1].size() <= 8) begin
      errors++;
      $display("FAIL k3b_r1c0 present: got %0d windows, expected more than 8", obs_q[1].size());
    end else begin
      o = obs_q[1][8];
      if (o.data[71:0] !== {8'h10, 64'h0} || o.full !== 1'b0) begin
        errors++;
        $display("FAIL k3b_r1c0: got data=%h full=%b, expected data=%h full=0", o.data[71:0], o.full, {8'h10, 64'h0});
      end
    end
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (obs_q[d].size() !== exp_q[d].size()) begin
        errors++;
        $display("FAIL basic_count dut%0d: got %0d windows, expected %0d", d, obs_q[d].size(), exp_q[d].size());
      end
      while (exp_q[d].size() > 0 && obs_q[d].size() > 0) begin
        e = exp_q[d].pop_front();
        o = obs_q[d].pop_front();
        checks++;
        if (o.cyc !== e.cyc || (o.data & e.mask) !== (e.data & e.mask) || o.full !== e.full) begin
          errors++;
          $display("FAIL basic_win dut%0d: got cyc=%0d data=%h full=%b, expected cyc=%0d data=%h full=%b",
                   d, o.cyc, o.data & e.mask, o.full, e.cyc, e.data, e.full);
        end
      end
      exp_q[d].delete();
      obs_q[d].delete();
    end
  endtask

  task automatic test_gappy();
    win_t e, o;
    start_frame();
    send_line(0, 8, 1, 1);
    for (int r = 1; r < 6; r++) send_line(r, 8, (r % 2 == 1) ? 1 : 2, 1);
    send_line(6, 5, 2, 1);
    repeat (6) drive(0, 0, 0, 8'h00);
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (obs_q[d].size() !== exp_q[d].size()) begin
        errors++;
        $display("FAIL gappy_count dut%0d: got %0d windows, expected %0d", d, obs_q[d].size(), exp_q[d].size());
      end
      while (exp_q[d].size() > 0 && obs_q[d].size() > 0) begin
        e = exp_q[d].pop_front();
        o = obs_q[d].pop_front();
        checks++;
        if (o.cyc !== e.cyc || (o.data & e.mask) !== (e.data & e.mask) || o.full !== e.full) begin
          errors++;
          $display("FAIL gappy_win dut%0d: got cyc=%0d data=%h full=%b, expected cyc=%0d data=%h full=%b",
                   d, o.cyc, o.data & e.mask, o.full, e.cyc, e.data, e.full);
        end
      end
      exp_q[d].delete();
      obs_q[d].delete();
    end
  endtask

  task automatic test_overflow();
    win_t e, o;
    start_frame();
    send_line(0, 8, 0, 1);
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (wer[d] !== 1'(m_err)) begin
        errors++;
        $display("FAIL ovf_before dut%0d: got err=%b, expected %b", d, wer[d], m_err);
      end
    end
    send_line(1, 9, 0, 1);
    repeat (3) drive(0, 0, 0, 8'h00);
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (wer[d] !== 1'(m_err) || m_err != 1'b1) begin
        errors++;
        $display("FAIL ovf_set dut%0d: got err=%b, expected 1", d, wer[d]);
      end
    end
    start_frame();
    send_line(0, 8, 2, 1);
    repeat (6) drive(0, 0, 0, 8'h00);
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (wer[d] !== 1'b1) begin
        errors++;
        $display("FAIL ovf_sticky dut%0d: got err=%b, expected 1", d, wer[d]);
      end
      checks++;
      if (obs_q[d].size() !== exp_q[d].size()) begin
        errors++;
        $display("FAIL ovf_count dut%0d: got %0d windows, expected %0d", d, obs_q[d].size(), exp_q[d].size());
      end
      while (exp_q[d].size() > 0 && obs_q[d].size() > 0) begin
        e = exp_q[d].pop_front();
        o = obs_q[d].pop_front();
        checks++;
        if (o.cyc !== e.cyc || (o.data & e.mask) !== (e.data & e.mask) || o.full !== e.full) begin
          errors++;
          $display("FAIL ovf_win dut%0d: got cyc=%0d data=%h full=%b, expected cyc=%0d data=%h full=%b",
                   d, o.cyc, o.data & e.mask, o.full, e.cyc, e.data, e.full);
        end
      end
      exp_q[d].delete();
      obs_q[d].delete();
    end
  endtask

  task automatic test_reset_midline();
    win_t e, o;
    start_frame();
    send_line(0, 8, 0, 1);
    drive(0, 1, 1, 8'h11);
    drive(0, 1, 1, 8'h22);
    drive(0, 1, 0, 8'h00);
    drive(0, 1, 1, 8'h33);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if ({wv[d], whr[d], wvl[d], wfl[d], wer[d]} !== 5'b0 || get_wd(d) !== 200'h0) begin
        errors++;
        $display("FAIL midline_reset dut%0d: got ctl=%b data=%h, expected all 0", d,
                 {wv[d], whr[d], wvl[d], wfl[d], wer[d]}, get_wd(d));
      end
    end
    in_vsync = 1'b0;
    in_href  = 1'b0;
    in_valid = 1'b0;
    m_row = 0; m_col = 0; m_line_px = 0; m_err = 0; m_href_p = 0; m_vs_p = 0;
    for (int c = 0; c < IW; c++) colhist[c].delete();
    for (int d = 0; d < 3; d++) begin
      exp_q[d].delete();
      obs_q[d].delete();
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    start_frame();
    drive(0, 1, 1, 8'h5A);
    for (int c = 1; c < 8; c++) drive(0, 1, 1, 8'($urandom_range(0, 255)));
    drive(0, 0, 0, 8'h00);
    repeat (6) drive(0, 0, 0, 8'h00);
    checks++;
    if (obs_q[1].size() == 0) begin
      errors++;
      $display("FAIL post_reset_r0c0 present: got 0 windows, expected at least 1");
    end else begin
      o = obs_q[1][0];
      if (o.data[71:0] !== {8'h5A, 64'h0} || o.full !== 1'b0) begin
        errors++;
        $display("FAIL post_reset_r0c0: got data=%h full=%b, expected data=%h full=0", o.data[71:0], o.full, {8'h5A, 64'h0});
      end
    end
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (obs_q[d].size() !== exp_q[d].size()) begin
        errors++;
        $display("FAIL rst_count dut%0d: got %0d windows, expected %0d", d, obs_q[d].size(), exp_q[d].size());
      end
      while (exp_q[d].size() > 0 && obs_q[d].size() > 0) begin
        e = exp_q[d].pop_front();
        o = obs_q[d].pop_front();
        checks++;
        if (o.cyc !== e.cyc || (o.data & e.mask) !== (e.data & e.mask) || o.full !== e.full) begin
          errors++;
          $display("FAIL rst_win dut%0d: got cyc=%0d data=%h full=%b, expected cyc=%0d data=%h full=%b",
                   d, o.cyc, o.data & e.mask, o.full, e.cyc, e.data, e.full);
        end
      end
      exp_q[d].delete();
      obs_q[d].delete();
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_gappy();
    test_overflow();
    test_reset_midline();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
